// File: rtl/serial_adder_nbit.sv
// Multi-cycle adder: DIGIT full-adder slices per clock (each built from two half adders),
// ripple carry held between cycles, start/busy/done sequencing.
module serial_adder_nbit #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_next;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [WIDTH-1:0] op_a, op_b, res, res_next;
  logic [DIGIT-1:0] slice_sum;
  logic             slice_cout, msb_cin, last;

  assign last = (cnt == CW'(N - 1));
  assign busy = (state == RUN);
  assign done = (state == DONE);

  // Operands shift right each cycle so the current slice always sits in the low DIGIT bits.
  always_comb begin
    logic c, hs, hc;
    c         = carry;
    hs        = 1'b0;
    hc        = 1'b0;
    slice_sum = '0;
    msb_cin   = 1'b0;
    for (int i = 0; i < DIGIT; i++) begin
      hs           = op_a[i] ^ op_b[i];
      hc           = op_a[i] & op_b[i];
      slice_sum[i] = hs ^ c;
      msb_cin      = c;
      c            = hc | (hs & c);
    end
    slice_cout = c;
  end

  assign res_next = WIDTH'({slice_sum, res} >> DIGIT);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last)  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Result bits enter at the top of res, so after N slices it holds the full sum in order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      carry <= 1'b0;
      op_a  <= '0;
      op_b  <= '0;
      res   <= '0;
      sum   <= '0;
      c_out <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_a  <= a;
            op_b  <= b;
            carry <= c_in;
            cnt   <= '0;
          end
        end
        RUN: begin
          op_a  <= op_a >> DIGIT;
          op_b  <= op_b >> DIGIT;
          carry <= slice_cout;
          res   <= res_next;
          if (last) begin
            cnt   <= '0;
            sum   <= res_next;
            c_out <= slice_cout;
            ovf   <= msb_cin ^ slice_cout;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_nbit.sv
// Directed self-checking bench for serial_adder_nbit: one 8-bit/1-digit and one
// 16-bit/4-digit instance sharing a clock and reset.
module tb_serial_adder_nbit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start8, cin8, busy8, done8, cout8, ovf8;
  logic [7:0]  a8, b8, sum8;
  logic        start16, cin16, busy16, done16, cout16, ovf16;
  logic [15:0] a16, b16, sum16;

  int checks = 0;
  int errors = 0;

  serial_adder_nbit #(.WIDTH(8), .DIGIT(1)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .c_in(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .c_out(cout8), .ovf(ovf8)
  );

  serial_adder_nbit #(.WIDTH(16), .DIGIT(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16), .c_in(cin16),
    .busy(busy16), .done(done16), .sum(sum16), .c_out(cout16), .ovf(ovf16)
  );

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Starts one add, then counts edges until done while watching busy, exclusivity and sum hold.
  task automatic applyStimulus(input bit wide, input logic [15:0] av, input logic [15:0] bv,
                               input logic cv, input bit inject, input logic [15:0] prev_sum,
                               output int lat, output int busy_cycles, output int excl_viol,
                               output bit held);
    logic d, bz;
    logic [15:0] s;
    lat = 0; busy_cycles = 0; excl_viol = 0; held = 1'b1;
    if (wide) begin a16 = av; b16 = bv; cin16 = cv; start16 = 1'b1; end
    else      begin a8 = av[7:0]; b8 = bv[7:0]; cin8 = cv; start8 = 1'b1; end
    @(posedge clk); #1;
    start8 = 1'b0; start16 = 1'b0;
    forever begin
      d  = wide ? done16 : done8;
      bz = wide ? busy16 : busy8;
      s  = wide ? sum16 : {8'h00, sum8};
      if (d || lat >= 40) break;
      if (bz) busy_cycles++;
      if (bz && d) excl_viol++;
      if (s !== prev_sum) held = 1'b0;
      if (inject && lat == 2) begin
        a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b0; start8 = 1'b1;
      end
      @(posedge clk); #1;
      start8 = 1'b0;
      lat++;
    end
    if (wide ? busy16 : busy8) excl_viol++;
  endtask

  task automatic checkResult(input string tag, input bit wide, input int lat, input int exp_lat,
                             input int bc, input int ev, input bit held,
                             input logic [15:0] exp_sum, input logic exp_c, input logic exp_v);
    checkOutput({tag, " latency"}, lat, exp_lat);
    checkOutput({tag, " busy_cycles"}, bc, exp_lat);
    checkOutput({tag, " busy_done_excl"}, ev, 0);
    checkOutput({tag, " sum_held"}, {31'd0, held}, 1);
    checkOutput({tag, " sum"}, wide ? sum16 : {8'h00, sum8}, exp_sum);
    checkOutput({tag, " c_out"}, wide ? cout16 : cout8, exp_c);
    checkOutput({tag, " ovf"}, wide ? ovf16 : ovf8, exp_v);
  endtask

  logic [7:0] va [4] = '{8'h3C, 8'hFF, 8'hFF, 8'h12};
  logic [7:0] vb [4] = '{8'h5A, 8'h01, 8'hFF, 8'h34};
  logic       vc [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
  logic [7:0] vs [4] = '{8'h96, 8'h00, 8'hFF, 8'h47};
  logic       vco[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
  logic       vov[4] = '{1'b1, 1'b0, 1'b0, 1'b0};

  initial begin
    int lat, bc, ev, k, dones;
    bit held;
    logic [15:0] prev;
    rst_n = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rst busy", busy8, 0);
    checkOutput("rst done", done8, 0);
    checkOutput("rst sum", sum8, 0);
    checkOutput("rst c_out", cout8, 0);
    checkOutput("rst ovf", ovf8, 0);
    checkOutput("rst sum16", sum16, 0);
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;

    prev = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, {8'h00, va[i]}, {8'h00, vb[i]}, vc[i], (i == 3), prev, lat, bc, ev, held);
      checkResult($sformatf("add8_%0d", i), 1'b0, lat, 8, bc, ev, held, {8'h00, vs[i]}, vco[i], vov[i]);
      @(posedge clk); #1;
      checkOutput($sformatf("add8_%0d done_drop", i), done8, 0);
      checkOutput($sformatf("add8_%0d idle_busy", i), busy8, 0);
      prev = {8'h00, vs[i]};
    end

    // Abort an add in flight with reset asserted between edges.
    a8 = 8'h55; b8 = 8'h55; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1 start8 = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("abort busy", busy8, 0);
    checkOutput("abort done", done8, 0);
    checkOutput("abort sum", sum8, 0);
    checkOutput("abort c_out", cout8, 0);
    checkOutput("abort ovf", ovf8, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    dones = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done8 || busy8) dones++;
    end
    checkOutput("abort no_done", dones, 0);
    applyStimulus(1'b0, 16'h007F, 16'h0001, 1'b0, 1'b0, 16'h0000, lat, bc, ev, held);
    checkResult("add8_after_abort", 1'b0, lat, 8, bc, ev, held, 16'h0080, 1'b0, 1'b1);
    @(posedge clk); #1;

    applyStimulus(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, lat, bc, ev, held);
    checkResult("add16", 1'b1, lat, 4, bc, ev, held, 16'h0000, 1'b1, 1'b0);
    // Hold start from the DONE cycle onward; the next add must be picked up as soon as IDLE allows.
    a16 = 16'h1234; b16 = 16'h4321; cin16 = 1'b0; start16 = 1'b1;
    k = 0;
    while (!busy16 && k < 4) begin
      @(posedge clk); #1;
      k++;
    end
    start16 = 1'b0;
    checkOutput("b2b accepted", busy16, 1);
    checkOutput("b2b sum_held", sum16, 16'h0000);
    lat = 0;
    while (!done16 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput("b2b latency", lat, 4);
    checkOutput("b2b sum", sum16, 16'h5555);
    checkOutput("b2b c_out", cout16, 0);
    checkOutput("b2b ovf", ovf16, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #90000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
